decode_issue: RTL and testbench

//  Instruction decode/issue stage sitting directly upstream of regfile. Latches one

---
 rtl/isa_pkg.sv | 78 +++++++
 rtl/decode_issue_if.sv | 33 +++
 rtl/reg_scoreboard.sv | 35 +++
 rtl/decode_issue.sv | 88 ++++++++
 tb/tb_decode_issue.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/isa_pkg.sv
// ISA constants, field positions, stage state encoding and the instruction decoder
// shared by the decode/issue slice.
package isa_pkg;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam int OP_HI = 31, OP_LO = 26;
    localparam int RS_HI = 25, RS_LO = 21;
    localparam int RT_HI = 20, RT_LO = 16;
    localparam int RD_HI = 15, RD_LO = 11;
    localparam int SH_HI = 10, SH_LO = 6;
    localparam int FN_HI = 5,  FN_LO = 0;
    localparam int IMM_HI = 15;

    typedef enum logic [1:0] {EMPTY, HELD, STALL} state_t;

    typedef struct packed {
        logic [4:0]      wadd;
        logic            wen;
        logic            illegal;
        logic [XLEN-1:0] imm;
    } dec_t;

    function automatic logic uses_rs(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI,
            OP_LW, OP_SW, OP_BEQ, OP_BNE: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rt(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_SW, OP_BEQ, OP_BNE: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

    // jal is deliberately not a writer here: regfile handles r31 and it is never scoreboarded
    function automatic dec_t decode(input logic [XLEN-1:0] instr);
        dec_t        d;
        logic [15:0] imm16;
        imm16     = instr[IMM_HI:0];
        d.wadd    = 5'd0;
        d.illegal = 1'b0;
        d.imm     = {{16{imm16[15]}}, imm16};
        case (instr[OP_HI:OP_LO])
            OP_RTYPE: d.wadd = instr[RD_HI:RD_LO];
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_LW: d.wadd = instr[RT_HI:RT_LO];
            OP_ANDI, OP_ORI: begin
                d.wadd = instr[RT_HI:RT_LO];
                d.imm  = {16'h0000, imm16};
            end
            OP_LUI: begin
                d.wadd = instr[RT_HI:RT_LO];
                d.imm  = {imm16, 16'h0000};
            end
            OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL: d.wadd = 5'd0;
            default: d.illegal = 1'b1;
        endcase
        d.wen = (d.wadd != 5'd0);
        return d;
    endfunction
endpackage

// File: rtl/decode_issue_if.sv
// Fetch-side and execute-side handshake bundle of the decode/issue stage.
// master = surrounding pipeline (fetch + execute), slave = decode stage.
interface decode_issue_if;
    import isa_pkg::*;

    logic            if_valid;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic            if_ready;

    logic            id_valid;
    logic            ex_ready;
    logic [5:0]      id_op_code;
    logic [5:0]      id_funct;
    logic [4:0]      id_shamt;
    logic [XLEN-1:0] id_imm;
    logic [4:0]      id_wadd;
    logic            id_wen;
    logic [XLEN-1:0] id_pc;
    logic            id_illegal;

    modport master (
        output if_valid, if_instr, if_pc, ex_ready,
        input  if_ready, id_valid, id_op_code, id_funct, id_shamt, id_imm,
               id_wadd, id_wen, id_pc, id_illegal
    );

    modport slave (
        input  if_valid, if_instr, if_pc, ex_ready,
        output if_ready, id_valid, id_op_code, id_funct, id_shamt, id_imm,
               id_wadd, id_wen, id_pc, id_illegal
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, r0 never busy.
// Lookups see the post-edge value so the stage can pick HELD/STALL at the same edge.
module reg_scoreboard #(
    parameter int NREGS = 32
) (
    input  logic       clk,
    input  logic       res,
    input  logic       set_en,
    input  logic [4:0] set_addr,
    input  logic       clr_en,
    input  logic [4:0] clr_addr,
    input  logic [4:0] look_addr1,
    input  logic [4:0] look_addr2,
    output logic       look_busy1,
    output logic       look_busy2
);
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;

    // set applied after clear so a same-edge set/clear of one register leaves it busy
    always_comb begin
        busy_nxt = busy;
        if (clr_en) busy_nxt[clr_addr] = 1'b0;
        if (set_en) busy_nxt[set_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) busy <= '0;
        else      busy <= busy_nxt;
    end

    assign look_busy1 = busy_nxt[look_addr1];
    assign look_busy2 = busy_nxt[look_addr2];
endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: one-entry holding register, RAW-hazard scoreboard and decoder
// feeding regfile read addresses and the execute handshake.
module decode_issue
    import isa_pkg::*;
#(
    parameter int NREGS = isa_pkg::NREGS
) (
    input  logic                 clk,
    input  logic                 res,
    decode_issue_if.slave        bus,
    output logic [4:0]           radd1,
    output logic [4:0]           radd2,
    input  logic                 wb_wen,
    input  logic [4:0]           wb_wadd,
    input  logic                 flush
);
    state_t          state;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    dec_t            dec;
    logic            accept;
    logic            issue;
    logic [5:0]      nxt_op;
    logic [4:0]      nxt_rs;
    logic [4:0]      nxt_rt;
    logic            nxt_busy1;
    logic            nxt_busy2;
    logic            hazard_nxt;

    assign bus.if_ready = (state == EMPTY) || ((state == HELD) && bus.ex_ready);
    assign accept       = bus.if_valid && bus.if_ready;
    assign bus.id_valid = (state == HELD) && !flush;
    assign issue        = bus.id_valid && bus.ex_ready;

    // Whatever occupies the holding register after this edge decides HELD vs STALL
    assign nxt_op = accept ? bus.if_instr[OP_HI:OP_LO] : instr[OP_HI:OP_LO];
    assign nxt_rs = accept ? bus.if_instr[RS_HI:RS_LO] : instr[RS_HI:RS_LO];
    assign nxt_rt = accept ? bus.if_instr[RT_HI:RT_LO] : instr[RT_HI:RT_LO];

    assign dec        = decode(instr);
    assign hazard_nxt = (nxt_busy1 && uses_rs(nxt_op)) || (nxt_busy2 && uses_rt(nxt_op));

    reg_scoreboard #(.NREGS(NREGS)) u_scoreboard (
        .clk        (clk),
        .res        (res),
        .set_en     (issue && dec.wen),
        .set_addr   (dec.wadd),
        .clr_en     (wb_wen),
        .clr_addr   (wb_wadd),
        .look_addr1 (nxt_rs),
        .look_addr2 (nxt_rt),
        .look_busy1 (nxt_busy1),
        .look_busy2 (nxt_busy2)
    );

    // state | meaning
    // EMPTY | nothing held, fetch may present
    // HELD  | instruction held, sources ready, offered to execute
    // STALL | instruction held, waiting on a pending writeback
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state <= EMPTY;
            instr <= '0;
            pc    <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else if (accept) begin
            instr <= bus.if_instr;
            pc    <= bus.if_pc;
            state <= hazard_nxt ? STALL : HELD;
        end else if (issue) begin
            state <= EMPTY;
        end else if (state == STALL) begin
            state <= hazard_nxt ? STALL : HELD;
        end
    end

    assign radd1          = instr[RS_HI:RS_LO];
    assign radd2          = instr[RT_HI:RT_LO];
    assign bus.id_op_code = instr[OP_HI:OP_LO];
    assign bus.id_funct   = instr[FN_HI:FN_LO];
    assign bus.id_shamt   = instr[SH_HI:SH_LO];
    assign bus.id_imm     = dec.imm;
    assign bus.id_wadd    = dec.wadd;
    assign bus.id_wen     = dec.wen;
    assign bus.id_pc      = pc;
    assign bus.id_illegal = dec.illegal;
endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: occupancy/busy-set reference model checked every negedge,
// plus directed sequences with literal expectations.
module tb_decode_issue;
    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic [4:0] radd1, radd2;
    logic       wb_wen = 1'b0;
    logic [4:0] wb_wadd = 5'd0;
    logic       flush = 1'b0;

    decode_issue_if bus();

    decode_issue dut (
        .clk     (clk),
        .res     (res),
        .bus     (bus),
        .radd1   (radd1),
        .radd2   (radd2),
        .wb_wen  (wb_wen),
        .wb_wadd (wb_wadd),
        .flush   (flush)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [4:0]  wadd;
        logic        wen;
        logic        ors;
        logic        ort;
        logic        ill;
        logic [31:0] imm;
    } rdec_t;

    function automatic rdec_t ref_dec(input logic [31:0] w);
        rdec_t d;
        d = '0;
        d.imm = {{16{w[15]}}, w[15:0]};
        case (w[31:26])
            6'h00: begin d.wadd = w[15:11]; d.ors = 1'b1; d.ort = 1'b1; end
            6'h08, 6'h09, 6'h0A, 6'h23: begin d.wadd = w[20:16]; d.ors = 1'b1; end
            6'h0C, 6'h0D: begin d.wadd = w[20:16]; d.ors = 1'b1; d.imm = {16'h0, w[15:0]}; end
            6'h0F: begin d.wadd = w[20:16]; d.imm = {w[15:0], 16'h0}; end
            6'h2B, 6'h04, 6'h05: begin d.ors = 1'b1; d.ort = 1'b1; end
            6'h02, 6'h03: d.ill = 1'b0;
            default: d.ill = 1'b1;
        endcase
        d.wen = (d.wadd != 5'd0);
        return d;
    endfunction

    // Reference model: an occupancy flag, the held word, and a set of pending registers
    logic        m_occ   = 1'b0;
    logic [31:0] m_instr = '0;
    logic [31:0] m_pc    = '0;
    logic [31:0] m_busy  = '0;
    rdec_t       m_du, m_dc;
    logic        t_iss, t_acc;

    function automatic logic f_haz();
        rdec_t d;
        d = ref_dec(m_instr);
        return (d.ors && m_instr[25:21] != 5'd0 && m_busy[m_instr[25:21]]) ||
               (d.ort && m_instr[20:16] != 5'd0 && m_busy[m_instr[20:16]]);
    endfunction

    function automatic logic e_valid();
        return m_occ && !f_haz() && !flush;
    endfunction

    function automatic logic e_ready();
        return !m_occ || (!f_haz() && bus.ex_ready);
    endfunction

    always @(posedge clk or negedge res) begin
        if (!res) begin
            m_occ   = 1'b0;
            m_instr = '0;
            m_pc    = '0;
            m_busy  = '0;
        end else begin
            m_du  = ref_dec(m_instr);
            t_iss = e_valid() && bus.ex_ready;
            t_acc = bus.if_valid && e_ready();
            if (wb_wen && wb_wadd != 5'd0) m_busy[wb_wadd] = 1'b0;
            if (t_iss && m_du.wen) m_busy[m_du.wadd] = 1'b1;
            if (flush) m_occ = 1'b0;
            else if (t_acc) begin
                m_occ   = 1'b1;
                m_instr = bus.if_instr;
                m_pc    = bus.if_pc;
            end else if (t_iss) m_occ = 1'b0;
        end
    end

    always @(negedge clk) begin
        m_dc = ref_dec(m_instr);
        chk("if_ready", 32'(bus.if_ready), 32'(e_ready()));
        chk("id_valid", 32'(bus.id_valid), 32'(e_valid()));
        chk("radd1", 32'(radd1), 32'(m_instr[25:21]));
        chk("radd2", 32'(radd2), 32'(m_instr[20:16]));
        if (e_valid()) begin
            chk("id_op_code", 32'(bus.id_op_code), 32'(m_instr[31:26]));
            chk("id_funct", 32'(bus.id_funct), 32'(m_instr[5:0]));
            chk("id_shamt", 32'(bus.id_shamt), 32'(m_instr[10:6]));
            chk("id_imm", bus.id_imm, m_dc.imm);
            chk("id_wadd", 32'(bus.id_wadd), 32'(m_dc.wadd));
            chk("id_wen", 32'(bus.id_wen), 32'(m_dc.wen));
            chk("id_pc", bus.id_pc, m_pc);
            chk("id_illegal", 32'(bus.id_illegal), 32'(m_dc.ill));
        end
    end

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] w, input logic [31:0] p);
        bus.if_valid = 1'b1;
        bus.if_instr = w;
        bus.if_pc    = p;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.if_valid = 1'b0;
        bus.if_instr = '0;
        bus.if_pc    = '0;
        bus.ex_ready = 1'b1;
        #12;
        chk("rst if_ready", 32'(bus.if_ready), 32'd1);
        chk("rst id_valid", 32'(bus.id_valid), 32'd0);
        chk("rst radd1", 32'(radd1), 32'd0);
        chk("rst id_imm", bus.id_imm, 32'd0);
        chk("rst id_wen", 32'(bus.id_wen), 32'd0);
        res = 1'b1;
        step();

        // independent addi pair, back to back
        present(enc_i(6'h08, 5'd0, 5'd1, 16'd5), 32'h100);
        step();
        chk("t2 valid0", 32'(bus.id_valid), 32'd1);
        chk("t2 imm0", bus.id_imm, 32'd5);
        chk("t2 wadd0", 32'(bus.id_wadd), 32'd1);
        present(enc_i(6'h08, 5'd0, 5'd2, 16'd7), 32'h104);
        step();
        chk("t2 valid1", 32'(bus.id_valid), 32'd1);
        chk("t2 imm1", bus.id_imm, 32'd7);
        chk("t2 wadd1", 32'(bus.id_wadd), 32'd2);
        bus.if_valid = 1'b0;
        step();
        chk("t2 drained", 32'(bus.id_valid), 32'd0);
        wb_wen = 1'b1; wb_wadd = 5'd1;
        step();
        wb_wadd = 5'd2;
        step();
        wb_wen = 1'b0;

        // RAW: sub waits on add's r3 writeback
        present(enc_r(5'd1, 5'd2, 5'd3, 6'h20), 32'h108);
        step();
        chk("t3 add valid", 32'(bus.id_valid), 32'd1);
        present(enc_r(5'd3, 5'd1, 5'd4, 6'h22), 32'h10C);
        step();
        present(enc_i(6'h0D, 5'd0, 5'd6, 16'hF0F0), 32'h110);
        for (int i = 0; i < 3; i++) begin
            chk("t3 stall valid", 32'(bus.id_valid), 32'd0);
            chk("t3 stall ready", 32'(bus.if_ready), 32'd0);
            if (i < 2) step();
        end
        wb_wen = 1'b1; wb_wadd = 5'd3;
        step();
        wb_wen = 1'b0;
        chk("t3 sub valid", 32'(bus.id_valid), 32'd1);
        chk("t3 sub funct", 32'(bus.id_funct), 32'h22);
        chk("t3 sub wadd", 32'(bus.id_wadd), 32'd4);
        chk("t3 sub radd1", 32'(radd1), 32'd3);
        step();
        chk("t3 ori imm", bus.id_imm, 32'h0000F0F0);
        chk("t3 ori wadd", 32'(bus.id_wadd), 32'd6);
        bus.if_valid = 1'b0;
        step();

        // execute back-pressure holds everything
        bus.ex_ready = 1'b0;
        present(enc_i(6'h23, 5'd0, 5'd7, 16'h0010), 32'h200);
        step();
        present(enc_i(6'h08, 5'd0, 5'd8, 16'd1), 32'h204);
        for (int i = 0; i < 3; i++) begin
            chk("t4 valid", 32'(bus.id_valid), 32'd1);
            chk("t4 if_ready", 32'(bus.if_ready), 32'd0);
            chk("t4 op", 32'(bus.id_op_code), 32'h23);
            chk("t4 imm", bus.id_imm, 32'h10);
            chk("t4 wadd", 32'(bus.id_wadd), 32'd7);
            chk("t4 radd2", 32'(radd2), 32'd7);
            chk("t4 pc", bus.id_pc, 32'h200);
            step();
        end
        bus.ex_ready = 1'b1;
        step();
        chk("t4 next wadd", 32'(bus.id_wadd), 32'd8);

        // flush beats a same-cycle accept
        flush = 1'b1;
        present(enc_i(6'h08, 5'd0, 5'd9, 16'd1), 32'h208);
        #1;
        chk("t5 flush valid", 32'(bus.id_valid), 32'd0);
        step();
        flush = 1'b0;
        bus.if_valid = 1'b0;
        chk("t5 empty valid", 32'(bus.id_valid), 32'd0);
        chk("t5 empty ready", 32'(bus.if_ready), 32'd1);
        present(enc_r(5'd8, 5'd0, 5'd10, 6'h20), 32'h20C);
        step();
        chk("t5 r8 free", 32'(bus.id_valid), 32'd1);
        present(enc_r(5'd7, 5'd0, 5'd11, 6'h20), 32'h210);
        step();
        bus.if_valid = 1'b0;
        chk("t5 r7 busy", 32'(bus.id_valid), 32'd0);
        wb_wen = 1'b1; wb_wadd = 5'd7;
        step();
        wb_wen = 1'b0;
        chk("t5 r7 done", 32'(bus.id_valid), 32'd1);
        step();

        // same-edge set and clear of r5: set wins
        present(enc_i(6'h23, 5'd0, 5'd5, 16'd4), 32'h300);
        step();
        wb_wen = 1'b1; wb_wadd = 5'd5;
        present(enc_r(5'd5, 5'd0, 5'd12, 6'h20), 32'h304);
        step();
        wb_wen = 1'b0;
        bus.if_valid = 1'b0;
        chk("t6 r5 busy", 32'(bus.id_valid), 32'd0);
        chk("t6 r5 ready", 32'(bus.if_ready), 32'd0);
        step();
        chk("t6 r5 still", 32'(bus.id_valid), 32'd0);
        wb_wen = 1'b1; wb_wadd = 5'd5;
        step();
        wb_wen = 1'b0;
        chk("t6 r5 released", 32'(bus.id_valid), 32'd1);
        present({6'h3F, 5'd12, 5'd12, 16'h1234}, 32'h308);
        step();
        chk("t6 ill valid", 32'(bus.id_valid), 32'd1);
        chk("t6 ill flag", 32'(bus.id_illegal), 32'd1);
        chk("t6 ill wen", 32'(bus.id_wen), 32'd0);
        present(enc_i(6'h08, 5'd0, 5'd0, 16'd3), 32'h30C);
        step();
        chk("t6 r0 wen", 32'(bus.id_wen), 32'd0);
        chk("t6 r0 ill", 32'(bus.id_illegal), 32'd0);
        present(enc_i(6'h0F, 5'd0, 5'd14, 16'h1234), 32'h310);
        step();
        chk("t6 lui imm", bus.id_imm, 32'h12340000);
        present(enc_i(6'h08, 5'd0, 5'd13, 16'hFFFC), 32'h314);
        step();
        chk("t6 neg imm", bus.id_imm, 32'hFFFFFFFC);
        present(32'h0800_0040, 32'h318);
        step();
        chk("t6 j wen", 32'(bus.id_wen), 32'd0);

        // async reset in the middle of a stall
        present(enc_r(5'd14, 5'd0, 5'd16, 6'h20), 32'h31C);
        step();
        bus.if_valid = 1'b0;
        chk("t1 pre stall", 32'(bus.id_valid), 32'd0);
        #2;
        res = 1'b0;
        #1;
        chk("t1 async valid", 32'(bus.id_valid), 32'd0);
        chk("t1 async ready", 32'(bus.if_ready), 32'd1);
        #3;
        res = 1'b1;
        wb_wen = 1'b1; wb_wadd = 5'd14;
        step();
        wb_wen = 1'b0;
        present(enc_r(5'd13, 5'd0, 5'd17, 6'h20), 32'h400);
        step();
        bus.if_valid = 1'b0;
        chk("t1 busy cleared", 32'(bus.id_valid), 32'd1);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
